// File: rtl/bin2bcd_seq_pkg.sv
// bin2bcd_seq shared types.
// FSM encoding and BCD digit width.
package bin2bcd_seq_pkg;
  localparam int BCD_DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/bin2bcd_seq_if.sv
// bin2bcd_seq request/result bundle.
// Master issues start/bin, slave returns busy/done/bcd/overflow.
interface bin2bcd_seq_if #(
  parameter int BIN_WIDTH = 16,
  parameter int DIGITS    = 5
);
  import bin2bcd_seq_pkg::*;

  logic                          start;
  logic [BIN_WIDTH-1:0]          bin;
  logic                          busy;
  logic                          done;
  logic [BCD_DIGIT_W*DIGITS-1:0] bcd;
  logic                          overflow;

  modport master (
    output start, bin,
    input  busy, done, bcd, overflow
  );

  modport slave (
    input  start, bin,
    output busy, done, bcd, overflow
  );
endinterface

// File: rtl/bin2bcd_seq_add3.sv
// Double-dabble digit correction cell.
// Adds 3 to a BCD digit of 5 or more before the shift.
module bin2bcd_seq_add3 (
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter.
// One shift per clock, start/busy/done handshake.
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int BIN_WIDTH = 16,
  parameter int DIGITS    = 5
) (
  input logic          clk,
  input logic          rst_n,
  bin2bcd_seq_if.slave bus
);
  localparam int AW = BCD_DIGIT_W * DIGITS;
  localparam int CW = $clog2(BIN_WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(BIN_WIDTH - 1);

  state_t               state;
  logic [CW-1:0]        count;
  logic [BIN_WIDTH-1:0] sreg;
  logic [AW-1:0]        acc;
  logic [AW-1:0]        adj;
  logic [AW-1:0]        acc_nxt;
  logic                 sticky;
  logic                 ovf_now;
  logic                 accept;
  logic                 last;
  logic                 busy_q;
  logic                 done_q;
  logic [AW-1:0]        bcd_q;
  logic                 ovf_q;

  assign accept = (state == IDLE) && bus.start;
  assign last   = (state == SHIFT) && (count == LAST);

  for (genvar i = 0; i < DIGITS; i++) begin : g_add3
    bin2bcd_seq_add3 u_add3 (
      .d (acc[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .q (adj[i*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // A set top bit after correction is the bit lost off the end
  assign ovf_now = adj[AW-1];
  assign acc_nxt = {adj[AW-2:0], sreg[BIN_WIDTH-1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      count  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= SHIFT;
            count  <= '0;
            busy_q <= 1'b1;
          end
        end
        SHIFT: begin
          count <= count + 1'b1;
          if (count == LAST) begin
            state  <= DONE;
            done_q <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg   <= '0;
      acc    <= '0;
      sticky <= 1'b0;
      bcd_q  <= '0;
      ovf_q  <= 1'b0;
    end else if (accept) begin
      sreg   <= bus.bin;
      acc    <= '0;
      sticky <= 1'b0;
    end else if (state == SHIFT) begin
      sreg   <= sreg << 1;
      acc    <= acc_nxt;
      sticky <= sticky | ovf_now;
      if (last) begin
        bcd_q <= acc_nxt;
        ovf_q <= sticky | ovf_now;
      end
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.bcd      = bcd_q;
  assign bus.overflow = ovf_q;
endmodule
